// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler: round-robin front end for one shared combinational
// floating-point add/subtract datapath. It accepts one operation from one of two
// requesters, drives the operands to the datapath, and waits SETTLE_CYCLES
// edges for the result to settle. It then holds the captured result until the
// consumer takes it.
`timescale 1ns/1ps

module fp_add_scheduler #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [34:0] req0_data,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [34:0] req1_data,

    output logic [10:0] fp_inp1,
    output logic [10:0] fp_inp2,
    output logic        fp_sgn1,
    output logic        fp_sgn2,
    output logic [4:0]  fp_exp1,
    output logic [4:0]  fp_exp2,
    output logic        fp_op,

    input  logic [10:0] fp_out,
    input  logic        fp_sgnout,
    input  logic [5:0]  fp_outexp,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [17:0] rsp_data,
    output logic [15:0] op_count
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned REQ_W  = 35;
    localparam int unsigned RSP_W  = 18;
    localparam int unsigned OPC_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_grant_q, last_grant_d;
    logic [REQ_W-1:0]   opnd_q, opnd_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic [RSP_W-1:0]   rsp_data_q, rsp_data_d;
    logic [OPC_W-1:0]   op_count_q, op_count_d;

    logic               grant_c;
    logic               accept_c;
    logic               settled_c;
    logic               consume_c;

    // Round-robin pick: on contention the requester that did not win last time.
    always_comb begin
        grant_c = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_c = ~last_grant_q;
        end else begin
            grant_c = ~req0_valid;
        end
    end

    assign settled_c = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
    assign consume_c = (state_q == ST_DONE) && rsp_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept_c)  state_d = ST_ISSUE;
            ST_ISSUE: if (settled_c) state_d = ST_DONE;
            ST_DONE:  if (rsp_ready) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs and datapath register next values.
    always_comb begin
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        opnd_d       = opnd_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        op_count_d   = op_count_q;

        if (state_q == ST_IDLE) begin
            req0_ready = req0_valid && !grant_c;
            req1_ready = req1_valid &&  grant_c;
        end
        accept_c = req0_ready || req1_ready;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    opnd_d       = grant_c ? req1_data : req0_data;
                    rsp_id_d     = grant_c;
                    last_grant_d = grant_c;
                    cnt_d        = '0;
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (settled_c) begin
                    rsp_data_d  = {fp_sgnout, fp_outexp, fp_out};
                    rsp_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (consume_c) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + OPC_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            opnd_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            op_count_q   <= '0;
        end else begin
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            opnd_q       <= opnd_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            op_count_q   <= op_count_d;
        end
    end

    assign fp_op     = opnd_q[34];
    assign fp_sgn1   = opnd_q[33];
    assign fp_exp1   = opnd_q[32:28];
    assign fp_inp1   = opnd_q[27:17];
    assign fp_sgn2   = opnd_q[16];
    assign fp_exp2   = opnd_q[15:11];
    assign fp_inp2   = opnd_q[10:0];

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign op_count  = op_count_q;

endmodule
